// File: rtl/mips_pkg.sv
// Opcodes and small helpers shared by the MIPS core decoder and the data memory.
package mips_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned OPCODE_W       = 6;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  localparam logic [OPCODE_W-1:0] OP_LB  = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_LH  = 6'b100001;
  localparam logic [OPCODE_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_SB  = 6'b101000;
  localparam logic [OPCODE_W-1:0] OP_SH  = 6'b101001;
  localparam logic [OPCODE_W-1:0] OP_SW  = 6'b101011;

  typedef logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] word_bytes_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } access_size_e;

  // Number of bytes a store opcode touches; SZ_NONE for anything that is not a store.
  function automatic access_size_e store_size(input logic [OPCODE_W-1:0] op);
    access_size_e sz;
    sz = SZ_NONE;
    case (op)
      OP_SB:   sz = SZ_BYTE;
      OP_SH:   sz = SZ_HALF;
      OP_SW:   sz = SZ_WORD;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mips_data_mem_if.sv
// MEM-stage bus between the core (master) and the data memory (slave).
interface mips_data_mem_if;
  import mips_pkg::*;

  logic [DATA_W-1:0]   mem_address;
  logic [DATA_W-1:0]   write_data;
  logic [OPCODE_W-1:0] opcode;
  logic                sig_mem_read;
  logic                sig_mem_write;
  logic [DATA_W-1:0]   read_data;

  modport master (
    output mem_address,
    output write_data,
    output opcode,
    output sig_mem_read,
    output sig_mem_write,
    input  read_data
  );

  modport slave (
    input  mem_address,
    input  write_data,
    input  opcode,
    input  sig_mem_read,
    input  sig_mem_write,
    output read_data
  );

endinterface

// File: rtl/mips_load_extend.sv
// Combinational load formatter: picks byte/half/word from {B3..B0} and sign- or zero-extends.
module mips_load_extend
  import mips_pkg::*;
(
  input  word_bytes_t         bytes,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [DATA_W-1:0]   ext_data_c
);

  always_comb begin
    ext_data_c = '0;
    case (opcode)
      OP_LB:   ext_data_c = {{24{bytes[0][7]}}, bytes[0]};
      OP_LBU:  ext_data_c = {24'h0, bytes[0]};
      OP_LH:   ext_data_c = {{16{bytes[1][7]}}, bytes[1], bytes[0]};
      OP_LHU:  ext_data_c = {16'h0, bytes[1], bytes[0]};
      OP_LW:   ext_data_c = {bytes[3], bytes[2], bytes[1], bytes[0]};
      default: ext_data_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_data_mem.sv
// Byte-addressable little-endian data memory: combinational loads, stores on the rising edge,
// unaligned accesses wrap at the top of memory.
module mips_data_mem
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned ADDR_BITS   = 10
) (
  input logic           clk,
  input logic           rst_n,
  mips_data_mem_if.slave bus
);

  logic [BYTE_W-1:0] mem [DEPTH_BYTES];

  logic [ADDR_BITS-1:0]                     base_addr;
  logic [BYTES_PER_WORD-1:0][ADDR_BITS-1:0] byte_addr;
  logic [BYTES_PER_WORD-1:0]                byte_we;
  word_bytes_t                              wr_bytes;
  word_bytes_t                              rd_bytes;
  logic [DATA_W-1:0]                        ext_data;
  logic                                     unused_addr_hi;

  assign base_addr      = bus.mem_address[ADDR_BITS-1:0];
  assign wr_bytes       = bus.write_data;
  assign unused_addr_hi = ^bus.mem_address[DATA_W-1:ADDR_BITS];

  // Lane i of an access sits at base+i; the ADDR_BITS-wide add gives the wraparound for free.
  always_comb begin
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      byte_addr[i] = base_addr + ADDR_BITS'(i);
    end
  end

  always_comb begin
    byte_we = '0;
    if (bus.sig_mem_write) begin
      case (store_size(bus.opcode))
        SZ_BYTE: byte_we = 4'b0001;
        SZ_HALF: byte_we = 4'b0011;
        SZ_WORD: byte_we = 4'b1111;
        default: byte_we = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < DEPTH_BYTES; j++) begin
        mem[j] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (byte_we[i]) begin
          mem[byte_addr[i]] <= wr_bytes[i];
        end
      end
    end
  end

  // Reads see the array directly, so a same-cycle store shows up only after the edge.
  always_comb begin
    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
      rd_bytes[i] = mem[byte_addr[i]];
    end
  end

  mips_load_extend u_load_extend (
    .bytes      (rd_bytes),
    .opcode     (bus.opcode),
    .ext_data_c (ext_data)
  );

  assign bus.read_data = bus.sig_mem_read ? ext_data : '0;

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_mips_data_mem;

  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic rst_n;

  mips_data_mem_if bus ();

  mips_data_mem #(
    .DEPTH_BYTES (DEPTH),
    .ADDR_BITS   (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ref_mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] ops [8] = '{6'b100000, 6'b100100, 6'b100001, 6'b100101,
                          6'b100011, 6'b101000, 6'b101001, 6'b101011};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a, input int unsigned i);
    return ref_mem[(int'(a % DEPTH) + i) % DEPTH];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [5:0] op,
                                             input logic rd);
    int v;
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_byte(a, 0);
    b1 = ref_byte(a, 1);
    b2 = ref_byte(a, 2);
    b3 = ref_byte(a, 3);
    if (!rd) return 32'h0;
    case (op)
      6'b100000: begin v = int'(b0); if (v >= 128) v -= 256; return 32'(v); end
      6'b100100: return 32'(int'(b0));
      6'b100001: begin
        v = int'(b0) + 256 * int'(b1);
        if (v >= 32768) v -= 65536;
        return 32'(v);
      end
      6'b100101: return 32'(int'(b0) + 256 * int'(b1));
      6'b100011: return {b3, b2, b1, b0};
      default:   return 32'h0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [5:0] op, input logic [31:0] d);
    int n;
    case (op)
      6'b101000: n = 1;
      6'b101001: n = 2;
      6'b101011: n = 4;
      default:   n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      ref_mem[(int'(a % DEPTH) + i) % DEPTH] = 8'((d >> (8 * i)) & 32'hFF);
    end
  endtask

  // Advance one clock edge, mirror its effect in the model, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'h00;
    end else if (bus.sig_mem_write) begin
      model_store(bus.mem_address, bus.opcode, bus.write_data);
    end
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [5:0] op,
                       input logic rd, input logic wr);
    bus.mem_address   = a;
    bus.write_data    = d;
    bus.opcode        = op;
    bus.sig_mem_read  = rd;
    bus.sig_mem_write = wr;
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [5:0] op);
    drive(a, 32'h0, op, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;
    logic [5:0]  op;
    int          lo;

    rst_n = 1'b0;
    drive(32'h0, 32'h0, 6'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    load(32'd1, 6'b100011);
    check("reset_lw1", bus.read_data, 32'h0000_0000);

    drive(32'd2, 32'h7FFF_FFFC, 6'b101011, 1'b0, 1'b1);
    step();
    load(32'd2, 6'b100011); check("sw_lw2",  bus.read_data, 32'h7FFF_FFFC);
    load(32'd2, 6'b100100); check("sw_lbu2", bus.read_data, 32'h0000_00FC);
    load(32'd2, 6'b100000); check("sw_lb2",  bus.read_data, 32'hFFFF_FFFC);
    load(32'd3, 6'b100101); check("sw_lhu3", bus.read_data, 32'h0000_FFFF);
    load(32'd3, 6'b100001); check("sw_lh3",  bus.read_data, 32'hFFFF_FFFF);

    // sb stores the low byte 0xFC to byte 5; sh then puts 0x78,0x56 at bytes 3,4.
    drive(32'd5, 32'h7FFF_FFFC, 6'b101000, 1'b0, 1'b1);
    step();
    drive(32'd3, 32'h1234_5678, 6'b101001, 1'b0, 1'b1);
    step();
    load(32'd2, 6'b100011); check("sb_sh_lw2", bus.read_data, 32'hFC56_78FC);

    drive(32'd2, 32'h0, 6'b100011, 1'b1, 1'b1);
    check("wr_loadop_pre", bus.read_data, 32'hFC56_78FC);
    step();
    check("wr_loadop_post", bus.read_data, 32'hFC56_78FC);
    drive(32'd2, 32'h0, 6'b101011, 1'b0, 1'b0);
    check("rd0_sw", bus.read_data, 32'h0);
    step();
    load(32'd2, 6'b100011); check("nowr_sw_lw2", bus.read_data, 32'hFC56_78FC);
    for (int k = 0; k < 8; k++) begin
      drive(32'd2, 32'h0, ops[k], 1'b0, 1'b0);
      check("rd0_op", bus.read_data, 32'h0);
    end
    load(32'd2, 6'b000000); check("bad_load_op", bus.read_data, 32'h0);

    drive(DEPTH - 2, 32'hAABB_CCDD, 6'b101011, 1'b0, 1'b1);
    step();
    load(DEPTH - 2, 6'b100100); check("wrap_b_top2", bus.read_data, 32'h0000_00DD);
    load(DEPTH - 1, 6'b100100); check("wrap_b_top1", bus.read_data, 32'h0000_00CC);
    load(32'd0,     6'b100100); check("wrap_b_0",    bus.read_data, 32'h0000_00BB);
    load(32'd1,     6'b100100); check("wrap_b_1",    bus.read_data, 32'h0000_00AA);
    load(DEPTH - 2, 6'b100011); check("wrap_lw",     bus.read_data, 32'hAABB_CCDD);
    load(DEPTH - 1, 6'b100001); check("wrap_lh",     bus.read_data, 32'hFFFF_BBCC);
    load(32'h8000_07FE, 6'b100011); check("alias_lw", bus.read_data, 32'hAABB_CCDD);

    rst_n = 1'b0;
    drive(32'd0, 32'hFFFF_FFFF, 6'b101011, 1'b1, 1'b1);
    step();
    rst_n = 1'b1;
    load(32'd0,     6'b100011); check("rst_wr_lw0",  bus.read_data, 32'h0);
    load(DEPTH - 2, 6'b100011); check("rst_wr_top",  bus.read_data, 32'h0);
    load(32'd2,     6'b100011); check("rst_wr_lw2",  bus.read_data, 32'h0);

    drive(32'd8, 32'h5566_7788, 6'b101011, 1'b0, 1'b1);
    step();
    load(32'd8, 6'b100011); check("rw_old", bus.read_data, 32'h5566_7788);
    drive(32'd8, 32'h1122_3344, 6'b101011, 1'b1, 1'b1);
    check("rw_store_op_pre", bus.read_data, 32'h0);
    step();
    load(32'd8, 6'b100011); check("rw_new", bus.read_data, 32'h1122_3344);

    for (int k = 0; k < 400; k++) begin
      r  = $urandom;
      a  = $urandom;
      d  = $urandom;
      lo = r[0] ? int'(r[8:4]) : 1008 + int'(r[7:4]);
      a[9:0] = 10'(lo);
      op = ops[r[11:9]];
      if (r[14:12] == 3'd0) op = 6'(r[20:15]);
      rst_n = (r[30:25] != 6'd0);
      drive(a, d, op, r[21], r[22]);
      check("rand_pre", bus.read_data, model_load(a, op, r[21]));
      step();
      check("rand_post", bus.read_data, model_load(a, op, r[21]));
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
